// File: rtl/tdc_pkg.sv
// Shared encodings and constants for the TDC controller and pulse_train_gen.
package tdc_pkg;

    typedef enum logic [1:0] {
        IDLE       = 2'b00,
        PULSE_HIGH = 2'b01,
        PULSE_LOW  = 2'b10,
        DONE       = 2'b11
    } state_t;

    localparam int MIN_PERIOD = 2;

endpackage

// File: rtl/period_timer.sv
// Loadable down-counter with enable and zero flag; holds at zero.
module period_timer #(
    parameter int PERIOD_BITS = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   load,
    input  logic                   en,
    input  logic [PERIOD_BITS-1:0] load_val,
    output logic                   zero
);

    logic [PERIOD_BITS-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (load)
            count_d = load_val;
        else if (en && (count_q != '0))
            count_d = count_q - PERIOD_BITS'(1);
    end

    always_ff @(posedge clk) begin
        if (rst)
            count_q <= '0;
        else
            count_q <= count_d;
    end

    assign zero = (count_q == '0);

endmodule

// File: rtl/pulse_train_gen.sv
// Emits count_in single-cycle pulses spaced period_in (min 2) cycles apart, then a done strobe.
// Optional abort input enabled by defining PULSE_TRAIN_GEN_ABORT_EN.
module pulse_train_gen
    import tdc_pkg::*;
#(
    parameter int COUNTER_BITS = 8,
    parameter int PERIOD_BITS  = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [COUNTER_BITS-1:0] count_in,
    input  logic [PERIOD_BITS-1:0]  period_in,
`ifdef PULSE_TRAIN_GEN_ABORT_EN
    input  logic                    abort,
`endif
    output logic                    pulse_out,
    output logic                    ready,
    output logic                    busy,
    output logic                    done
);

    state_t                  state_q, state_d;
    logic [COUNTER_BITS-1:0] remaining_q, remaining_d;
    logic [PERIOD_BITS-1:0]  eff_period_q, eff_period_d;
    logic                    tmr_load, tmr_en, tmr_zero;
    logic [PERIOD_BITS-1:0]  tmr_val;

    period_timer #(.PERIOD_BITS(PERIOD_BITS)) u_low_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load),
        .en       (tmr_en),
        .load_val (tmr_val),
        .zero     (tmr_zero)
    );

    always_comb begin
        state_d      = state_q;
        remaining_d  = remaining_q;
        eff_period_d = eff_period_q;
        tmr_load     = 1'b0;
        tmr_en       = 1'b0;
        // Loading eff_period-2 gives a low phase of eff_period-1 cycles.
        tmr_val      = eff_period_q - PERIOD_BITS'(MIN_PERIOD);
        case (state_q)
            IDLE: begin
                if (start) begin
                    remaining_d  = count_in;
                    eff_period_d = (period_in < PERIOD_BITS'(MIN_PERIOD))
                                   ? PERIOD_BITS'(MIN_PERIOD) : period_in;
                    state_d      = (count_in == '0) ? DONE : PULSE_HIGH;
                end
            end
            PULSE_HIGH: begin
                if (remaining_q == COUNTER_BITS'(1)) begin
                    state_d = DONE;
                end else begin
                    remaining_d = remaining_q - COUNTER_BITS'(1);
                    tmr_load    = 1'b1;
                    state_d     = PULSE_LOW;
                end
            end
            PULSE_LOW: begin
                if (tmr_zero)
                    state_d = PULSE_HIGH;
                else
                    tmr_en = 1'b1;
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
`ifdef PULSE_TRAIN_GEN_ABORT_EN
        if (abort)
            state_d = IDLE;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            remaining_q  <= '0;
            eff_period_q <= '0;
        end else begin
            state_q      <= state_d;
            remaining_q  <= remaining_d;
            eff_period_q <= eff_period_d;
        end
    end

    assign pulse_out = (state_q == PULSE_HIGH);
    assign ready     = (state_q == IDLE);
    assign busy      = (state_q == PULSE_HIGH) || (state_q == PULSE_LOW);
    assign done      = (state_q == DONE);

endmodule

// File: tb/tb_pulse_train_gen.sv
// Directed bench for pulse_train_gen: per-cycle output traces compared to hand-built expectations.
module tb_pulse_train_gen;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic [7:0] count_in = '0;
    logic [3:0] period_in = '0;
    logic       pulse_out, ready, busy, done;

    int checks = 0;
    int failures = 0;

    logic [1023:0] pulse_v, done_v, ready_v, busy_v;
    logic [1023:0] exp_p, exp_d, exp_r, exp_b;

    pulse_train_gen #(.COUNTER_BITS(8), .PERIOD_BITS(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .count_in  (count_in),
        .period_in (period_in),
        .pulse_out (pulse_out),
        .ready     (ready),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    // Launch at edge 0, then record outputs for cycles 1..n (sampled 1 time unit after each edge).
    task automatic run(input int cnt, input int per, input int n, input int inj_c,
                       input int inj_cnt, input int rst_c, input bit hold);
        pulse_v = '0; done_v = '0; ready_v = '0; busy_v = '0;
        count_in  = cnt[7:0];
        period_in = per[3:0];
        start     = 1'b1;
        @(posedge clk); #1;
        for (int c = 1; c <= n; c++) begin
            pulse_v[c] = pulse_out;
            done_v[c]  = done;
            ready_v[c] = ready;
            busy_v[c]  = busy;
            start = hold || (c == inj_c);
            if (c == inj_c) count_in = inj_cnt[7:0];
            rst = (c == rst_c);
            @(posedge clk); #1;
        end
        start = 1'b0;
        rst   = 1'b0;
    endtask

    task automatic wait_ready();
        int k = 0;
        while (!ready && k < 600) begin
            @(posedge clk); #1;
            k++;
        end
        checks++;
        if (ready !== 1'b1) begin
            failures++;
            $display("FAIL wait_ready: ready=%b required 1 within 600 cycles", ready);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b1; count_in = 8'd3; period_in = 4'd4;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0; start = 1'b0;
        checks++;
        if ({pulse_out, ready, busy, done} !== 4'b0100) begin
            failures++;
            $display("FAIL reset_outputs: pulse/ready/busy/done=%b required 0100",
                     {pulse_out, ready, busy, done});
        end
    endtask

    task automatic test_basic();
        run(3, 4, 12, 0, 0, 0, 1'b0);
        exp_p = '0; exp_p[1] = 1'b1; exp_p[5] = 1'b1; exp_p[9] = 1'b1;
        exp_d = '0; exp_d[10] = 1'b1;
        exp_r = '0; exp_r[11] = 1'b1; exp_r[12] = 1'b1;
        exp_b = '0; for (int i = 1; i <= 9; i++) exp_b[i] = 1'b1;
        checks++;
        if (pulse_v !== exp_p) begin
            failures++; $display("FAIL basic_pulse: got %h required %h", pulse_v[15:0], exp_p[15:0]);
        end
        checks++;
        if (done_v !== exp_d) begin
            failures++; $display("FAIL basic_done: got %h required %h", done_v[15:0], exp_d[15:0]);
        end
        checks++;
        if (ready_v !== exp_r) begin
            failures++; $display("FAIL basic_ready: got %h required %h", ready_v[15:0], exp_r[15:0]);
        end
        checks++;
        if (busy_v !== exp_b) begin
            failures++; $display("FAIL basic_busy: got %h required %h", busy_v[15:0], exp_b[15:0]);
        end
        wait_ready();
    endtask

    task automatic test_zero_count();
        run(0, 5, 4, 0, 0, 0, 1'b0);
        exp_p = '0;
        exp_d = '0; exp_d[1] = 1'b1;
        exp_r = '0; for (int i = 2; i <= 4; i++) exp_r[i] = 1'b1;
        checks++;
        if (pulse_v !== exp_p) begin
            failures++; $display("FAIL zero_pulse: got %h required %h", pulse_v[15:0], exp_p[15:0]);
        end
        checks++;
        if (done_v !== exp_d || ready_v !== exp_r) begin
            failures++;
            $display("FAIL zero_done_ready: done %h ready %h required done %h ready %h",
                     done_v[15:0], ready_v[15:0], exp_d[15:0], exp_r[15:0]);
        end
        wait_ready();
    endtask

    task automatic test_period_clamp();
        for (int p = 0; p <= 1; p++) begin
            run(2, p, 6, 0, 0, 0, 1'b0);
            exp_p = '0; exp_p[1] = 1'b1; exp_p[3] = 1'b1;
            exp_d = '0; exp_d[4] = 1'b1;
            checks++;
            if (pulse_v !== exp_p) begin
                failures++;
                $display("FAIL clamp_pulse p=%0d: got %h required %h", p, pulse_v[15:0], exp_p[15:0]);
            end
            checks++;
            if (done_v !== exp_d) begin
                failures++;
                $display("FAIL clamp_done p=%0d: got %h required %h", p, done_v[15:0], exp_d[15:0]);
            end
            wait_ready();
        end
    endtask

    task automatic test_max_count();
        int n_p;
        run(255, 2, 512, 0, 0, 0, 1'b0);
        exp_p = '0; for (int i = 1; i <= 509; i += 2) exp_p[i] = 1'b1;
        exp_d = '0; exp_d[510] = 1'b1;
        exp_r = '0; exp_r[511] = 1'b1; exp_r[512] = 1'b1;
        n_p = 0;
        for (int i = 1; i <= 512; i++) n_p += int'(pulse_v[i]);
        checks++;
        if (pulse_v !== exp_p) begin
            failures++; $display("FAIL max_pulse_pattern: pulse trace differs from odd cycles 1..509");
        end
        checks++;
        if (n_p != 255) begin
            failures++; $display("FAIL max_pulse_count: got %0d required 255", n_p);
        end
        checks++;
        if (done_v !== exp_d || ready_v !== exp_r) begin
            failures++; $display("FAIL max_done_ready: done/ready trace differs (done at 510, ready from 511)");
        end
        wait_ready();
    endtask

    task automatic test_start_while_busy();
        run(3, 4, 12, 4, 7, 0, 1'b0);
        exp_p = '0; exp_p[1] = 1'b1; exp_p[5] = 1'b1; exp_p[9] = 1'b1;
        exp_d = '0; exp_d[10] = 1'b1;
        checks++;
        if (pulse_v !== exp_p || done_v !== exp_d) begin
            failures++;
            $display("FAIL busy_start_ignored: pulse %h done %h required pulse %h done %h",
                     pulse_v[15:0], done_v[15:0], exp_p[15:0], exp_d[15:0]);
        end
        wait_ready();
    endtask

    task automatic test_reset_mid();
        run(3, 4, 14, 0, 0, 6, 1'b0);
        exp_p = '0; exp_p[1] = 1'b1; exp_p[5] = 1'b1;
        exp_r = '0; for (int i = 7; i <= 14; i++) exp_r[i] = 1'b1;
        checks++;
        if (pulse_v !== exp_p) begin
            failures++; $display("FAIL midrst_pulse: got %h required %h", pulse_v[15:0], exp_p[15:0]);
        end
        checks++;
        if (done_v !== '0) begin
            failures++; $display("FAIL midrst_done: got %h required 0", done_v[15:0]);
        end
        checks++;
        if (ready_v !== exp_r) begin
            failures++; $display("FAIL midrst_ready: got %h required %h", ready_v[15:0], exp_r[15:0]);
        end
    endtask

    task automatic test_back_to_back();
        run(1, 2, 8, 0, 0, 0, 1'b1);
        exp_p = '0; exp_p[1] = 1'b1; exp_p[4] = 1'b1; exp_p[7] = 1'b1;
        exp_d = '0; exp_d[2] = 1'b1; exp_d[5] = 1'b1; exp_d[8] = 1'b1;
        exp_r = '0; exp_r[3] = 1'b1; exp_r[6] = 1'b1;
        checks++;
        if (pulse_v !== exp_p) begin
            failures++; $display("FAIL b2b_pulse: got %h required %h", pulse_v[15:0], exp_p[15:0]);
        end
        checks++;
        if (done_v !== exp_d || ready_v !== exp_r) begin
            failures++;
            $display("FAIL b2b_done_ready: done %h ready %h required done %h ready %h",
                     done_v[15:0], ready_v[15:0], exp_d[15:0], exp_r[15:0]);
        end
        wait_ready();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_zero_count();
        test_period_clamp();
        test_max_count();
        test_start_while_busy();
        test_reset_mid();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
